// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ID/EX ALU control stage.
// Holds the ALU operation codes, major opcodes and funct7 patterns.
package alu_ctrl_pkg;

   typedef enum logic [3:0] {
      AluAnd  = 4'b0000,
      AluOr   = 4'b0001,
      AluAdd  = 4'b0010,
      AluJalr = 4'b0011,
      AluSlt  = 4'b0100,
      AluXor  = 4'b0101,
      AluSub  = 4'b0110,
      AluBeq  = 4'b1000,
      AluBne  = 4'b1001,
      AluBlt  = 4'b1010,
      AluBge  = 4'b1011,
      AluSll  = 4'b1101,
      AluSrl  = 4'b1110,
      AluSra  = 4'b1111
   } alu_op_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7 into ALU op, operand-B select
// and an illegal-instruction flag.
module alu_op_decode
   import alu_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output alu_op_e    op_o,
   output logic       alusrc_o,
   output logic       illegal_o
);

   logic f7_base;
   logic f7_alt;

   assign f7_base = (funct7_i == F7_BASE);
   assign f7_alt  = (funct7_i == F7_ALT);

   always_comb begin
      op_o      = AluAnd;
      alusrc_o  = 1'b0;
      illegal_o = 1'b0;
      unique case (opcode_i)
         OP_RTYPE, OP_IALU: begin
            alusrc_o = (opcode_i == OP_IALU);
            unique case (funct3_i)
               3'b000: begin
                  // Immediate form has no SUB; funct7 is part of the immediate.
                  if (opcode_i == OP_IALU || f7_base) op_o = AluAdd;
                  else if (f7_alt)                     op_o = AluSub;
                  else                                 illegal_o = 1'b1;
               end
               3'b001: begin
                  if (f7_base) op_o = AluSll;
                  else         illegal_o = 1'b1;
               end
               3'b010: begin
                  if (opcode_i == OP_IALU || f7_base) op_o = AluSlt;
                  else                                 illegal_o = 1'b1;
               end
               3'b100: begin
                  if (opcode_i == OP_IALU || f7_base) op_o = AluXor;
                  else                                 illegal_o = 1'b1;
               end
               3'b101: begin
                  if (f7_base)     op_o = AluSrl;
                  else if (f7_alt) op_o = AluSra;
                  else             illegal_o = 1'b1;
               end
               3'b110: begin
                  if (opcode_i == OP_IALU || f7_base) op_o = AluOr;
                  else                                 illegal_o = 1'b1;
               end
               3'b111: begin
                  if (opcode_i == OP_IALU || f7_base) op_o = AluAnd;
                  else                                 illegal_o = 1'b1;
               end
               default: illegal_o = 1'b1;
            endcase
         end
         OP_LOAD, OP_STORE, OP_JAL, OP_LUI: begin
            op_o     = AluAdd;
            alusrc_o = 1'b1;
         end
         OP_BRANCH: begin
            unique case (funct3_i)
               3'b000:  op_o = AluBeq;
               3'b001:  op_o = AluBne;
               3'b100:  op_o = AluBlt;
               3'b101:  op_o = AluBge;
               default: illegal_o = 1'b1;
            endcase
         end
         OP_JALR: begin
            if (funct3_i == 3'b000) begin
               op_o     = AluJalr;
               alusrc_o = 1'b1;
            end else begin
               illegal_o = 1'b1;
            end
         end
         default: illegal_o = 1'b1;
      endcase
      if (illegal_o) begin
         op_o     = AluAnd;
         alusrc_o = 1'b0;
      end
   end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX boundary register for ALU control with reset > flush > stall > capture
// priority and a saturating count of captured illegal instructions.
module alu_ctrl_stage
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_LENGTH = 4,
   parameter int unsigned CNT_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_i,
   input  logic [6:0]               opcode_i,
   input  logic [2:0]               funct3_i,
   input  logic [6:0]               funct7_i,
   input  logic                     stall_i,
   input  logic                     flush_i,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     ALUSrc_o,
   output logic                     valid_o,
   output logic                     illegal_o,
   output logic [CNT_WIDTH-1:0]     illegal_cnt_o
);

   alu_op_e dec_op;
   logic    dec_alusrc;
   logic    dec_illegal;

   alu_op_decode u_decode (
      .opcode_i  (opcode_i),
      .funct3_i  (funct3_i),
      .funct7_i  (funct7_i),
      .op_o      (dec_op),
      .alusrc_o  (dec_alusrc),
      .illegal_o (dec_illegal)
   );

   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic                     alusrc_q, alusrc_d;
   logic                     valid_q, valid_d;
   logic                     illegal_q, illegal_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

   always_comb begin
      op_d      = op_q;
      alusrc_d  = alusrc_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;
      if (flush_i) begin
         op_d      = '0;
         alusrc_d  = 1'b0;
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (!stall_i) begin
         valid_d = valid_i;
         if (valid_i) begin
            op_d      = OPCODE_LENGTH'(dec_op);
            alusrc_d  = dec_alusrc;
            illegal_d = dec_illegal;
            if (dec_illegal && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
         end else begin
            op_d      = '0;
            alusrc_d  = 1'b0;
            illegal_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= '0;
         alusrc_q  <= 1'b0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         op_q      <= op_d;
         alusrc_q  <= alusrc_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign Operation     = op_q;
   assign ALUSrc_o      = alusrc_q;
   assign valid_o       = valid_q;
   assign illegal_o     = illegal_q;
   assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: directed scenarios plus randomized
// traffic compared against a table-driven reference model.
module tb_alu_ctrl_stage;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid_i = 1'b0;
   logic [6:0]    opcode_i = '0;
   logic [2:0]    funct3_i = '0;
   logic [6:0]    funct7_i = '0;
   logic          stall_i = 1'b0;
   logic          flush_i = 1'b0;
   logic [3:0]    Operation;
   logic          ALUSrc_o;
   logic          valid_o;
   logic          illegal_o;
   logic [CW-1:0] illegal_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   int exp_op, exp_cnt;
   bit exp_src, exp_valid, exp_ill, src_known;

   alu_ctrl_stage #(
      .OPCODE_LENGTH (4),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .valid_i       (valid_i),
      .opcode_i      (opcode_i),
      .funct3_i      (funct3_i),
      .funct7_i      (funct7_i),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .Operation     (Operation),
      .ALUSrc_o      (ALUSrc_o),
      .valid_o       (valid_o),
      .illegal_o     (illegal_o),
      .illegal_cnt_o (illegal_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode straight from the instruction table; returns -1 if illegal.
   function automatic int ref_op(input int opc, input int f3, input int f7, output bit src);
      int r;
      r   = -1;
      src = 1'b0;
      if (opc == 'h33 || opc == 'h13) begin
         int plain;
         case (f3)
            0: plain = 2;  1: plain = 13; 2: plain = 4;  4: plain = 5;
            5: plain = 14; 6: plain = 1;  7: plain = 0;  default: plain = -1;
         endcase
         if (opc == 'h33) begin
            if (f7 == 0) r = plain;
            else if (f7 == 'h20 && f3 == 0) r = 6;
            else if (f7 == 'h20 && f3 == 5) r = 15;
         end else begin
            src = 1'b1;
            if (f3 == 1 || f3 == 5) begin
               if (f7 == 0) r = plain;
               else if (f7 == 'h20 && f3 == 5) r = 15;
            end else begin
               r = plain;
            end
         end
      end else if (opc == 'h03 || opc == 'h23 || opc == 'h6f || opc == 'h37) begin
         r = 2; src = 1'b1;
      end else if (opc == 'h63) begin
         if (f3 == 0) r = 8; else if (f3 == 1) r = 9;
         else if (f3 == 4) r = 10; else if (f3 == 5) r = 11;
      end else if (opc == 'h67 && f3 == 0) begin
         r = 3; src = 1'b1;
      end
      if (r < 0) src = 1'b0;
      return r;
   endfunction

   task automatic step(input bit v, input int opc, input int f3, input int f7,
                       input bit st, input bit fl, input bit rst);
      int op;
      bit src;
      valid_i  = v;
      opcode_i = 7'(opc);
      funct3_i = 3'(f3);
      funct7_i = 7'(f7);
      stall_i  = st;
      flush_i  = fl;
      reset    = rst;
      op = ref_op(opc, f3, f7, src);
      if (rst) begin
         exp_op = 0; exp_src = 0; exp_valid = 0; exp_ill = 0; exp_cnt = 0; src_known = 1;
      end else if (fl) begin
         exp_op = 0; exp_src = 0; exp_valid = 0; exp_ill = 0; src_known = 1;
      end else if (!st) begin
         exp_valid = v;
         if (v) begin
            exp_ill   = (op < 0);
            exp_op    = exp_ill ? 0 : op;
            exp_src   = src;
            src_known = 1;
            if (exp_ill && exp_cnt < CMAX) exp_cnt++;
         end else begin
            exp_ill = 0; exp_op = 0; src_known = 0;
         end
      end
      @(posedge clk);
      #1;
      check_eq("operation", int'(Operation), exp_op);
      check_eq("valid", int'(valid_o), int'(exp_valid));
      check_eq("illegal", int'(illegal_o), int'(exp_ill));
      check_eq("illegal_cnt", int'(illegal_cnt_o), exp_cnt);
      if (src_known) check_eq("alusrc", int'(ALUSrc_o), int'(exp_src));
   endtask

   initial begin
      exp_op = 0; exp_cnt = 0; exp_src = 0; exp_valid = 0; exp_ill = 0; src_known = 1;

      step(0, 0, 0, 0, 0, 0, 1);
      check_eq("reset_op", int'(Operation), 0);
      check_eq("reset_cnt", int'(illegal_cnt_o), 0);

      // R-type
      step(1, 'h33, 0, 'h20, 0, 0, 0);
      check_eq("rtype_sub", int'(Operation), 6);
      step(1, 'h33, 5, 'h20, 0, 0, 0);
      check_eq("rtype_sra", int'(Operation), 15);
      step(1, 'h33, 7, 0, 0, 0, 0);
      step(1, 'h33, 3, 0, 0, 0, 0);

      // I-type / memory
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, 'h13, 1, 1, 0, 0, 0);
      check_eq("islli_badf7_cnt", int'(illegal_cnt_o), 1);
      step(1, 'h03, 3, 'h55, 0, 0, 0);
      check_eq("load_src", int'(ALUSrc_o), 1);
      step(1, 'h13, 3, 0, 0, 0, 0);

      // Branch / JALR
      step(1, 'h63, 5, 0, 0, 0, 0);
      check_eq("bge", int'(Operation), 11);
      step(1, 'h63, 2, 0, 0, 0, 0);
      step(1, 'h67, 0, 0, 0, 0, 0);
      check_eq("jalr", int'(Operation), 3);
      step(1, 'h67, 1, 0, 0, 0, 0);
      step(0, 'h33, 0, 0, 0, 0, 0);

      // Stall then flush+stall
      step(1, 'h33, 0, 'h20, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 'h33, 0, 0, 1, 0, 0);
      check_eq("stall_hold_op", int'(Operation), 6);
      check_eq("stall_hold_valid", int'(valid_o), 1);
      step(1, 'h00, 0, 0, 1, 1, 0);
      check_eq("flush_valid", int'(valid_o), 0);

      // Saturation
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(1, 'h7f, i, 0, 0, 0, 0);
         check_eq("sat_cnt", int'(illegal_cnt_o), (i < 3) ? i + 1 : 3);
      end
      step(1, 'h00, 0, 0, 0, 1, 0);

      // Reset mid-stream
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, 'h00, 0, 0, 0, 0, 0);
      step(1, 'h00, 0, 0, 0, 0, 0);
      step(1, 'h37, 0, 0, 0, 0, 0);
      check_eq("pre_reset_cnt", int'(illegal_cnt_o), 2);
      step(1, 'h33, 0, 0, 0, 0, 1);
      check_eq("mid_reset_valid", int'(valid_o), 0);
      step(1, 'h33, 0, 0, 0, 0, 0);
      check_eq("post_reset_add", int'(Operation), 2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         int opc, f3, f7, sel;
         sel = $urandom_range(0, 9);
         case (sel)
            0: opc = 'h33; 1: opc = 'h13; 2: opc = 'h03; 3: opc = 'h23;
            4: opc = 'h63; 5: opc = 'h67; 6: opc = 'h6f; 7: opc = 'h37;
            8: opc = 'h33;
            default: opc = $urandom_range(0, 127);
         endcase
         f3 = $urandom_range(0, 7);
         sel = $urandom_range(0, 3);
         f7 = (sel == 0) ? 'h20 : (sel == 3) ? $urandom_range(0, 127) : 0;
         step($urandom_range(0, 3) != 0, opc, f3, f7,
              $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 63) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Producer side of the ALU's 4-bit `Operation` interface: decodes opcode/funct3/funct7 of the instruction leaving ID into the ALU operation code plus the operand-B select, and registers them into the ID/EX boundary with valid, stall and flush handling. Its outputs drive the EX-stage ALU directly. It also flags undecodable instructions and keeps a saturating count of them for debug.

## Interface
- `OPCODE_LENGTH`, 4, width of the ALU operation code
- `CNT_WIDTH`, 8, width of the illegal-instruction counter
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `valid_i`  in  1  ID holds an instruction to hand over
- `opcode_i`  in  7  instr[6:0]
- `funct3_i`  in  3  instr[14:12]
- `funct7_i`  in  7  instr[31:25]
- `stall_i`  in  1  hazard unit: hold EX register
- `flush_i`  in  1  branch/jump taken: kill EX register contents
- `Operation`  out  OPCODE_LENGTH  registered ALU operation
- `ALUSrc_o`  out  1  registered; 1 = SrcB from immediate
- `valid_o`  out  1  registered; EX slot holds a live instruction
- `illegal_o`  out  1  registered; captured instruction was undecodable
- `illegal_cnt_o`  out  CNT_WIDTH  illegal captures since reset, saturating

## Operation
- Op codes: AND 0000, OR 0001, ADD 0010, JALR 0011, SLT 0100, XOR 0101, SUB 0110, BEQ 1000, BNE 1001, BLT 1010, BGE 1011, SLL 1101, SRL 1110, SRA 1111; 0111/1100 never produced.
- R-type 0110011, ALUSrc=0: f3 000 ADD (f7=0000000) / SUB (f7=0100000); 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL (f7=0); 101 SRL (f7=0000000) / SRA (f7=0100000). Any other f3/f7 combination illegal.
- I-ALU 0010011, ALUSrc=1: f3 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND (f7 ignored); 001 SLL needs f7=0; 101 SRL/SRA as R-type. f3 011 and bad shift f7 illegal.
- Load 0000011, store 0100011: ADD, ALUSrc=1, funct fields ignored.
- Branch 1100011, ALUSrc=0: f3 000 BEQ, 001 BNE, 100 BLT, 101 BGE; others illegal.
- JALR 1100111 with f3=000: JALR, ALUSrc=1; other f3 illegal.
- JAL 1101111, LUI 0110111: ADD, ALUSrc=1.
- Any other opcode illegal. Illegal decode → Operation 0000, ALUSrc 0, illegal=1; valid still propagates so the trap logic sees it.
- Counter increments by 1 on each cycle the register captures a valid illegal instruction; holds at 2^CNT_WIDTH-1.

## Timing
- Latency 1 cycle: decode of inputs at edge N is visible on outputs after edge N.
- Per edge, priority reset > flush > stall > capture.
- reset: Operation=0000, ALUSrc_o=0, valid_o=0, illegal_o=0, illegal_cnt_o=0; mid-operation reset discards the EX slot and clears the counter.
- flush_i=1: valid_o←0, illegal_o←0, Operation←0000, ALUSrc_o←0; counter not incremented, even with stall_i=1 the same cycle.
- stall_i=1 (no flush): every output holds, inputs ignored, counter unchanged.
- Capture: all fields load from decode; valid_o←valid_i. With valid_i=0, valid_o=0, illegal_o=0, Operation=0000.
- Counter at max plus another illegal capture: stays at max, no wrap.

## Structure
- Package `alu_ctrl_pkg`: `alu_op_e` enum (4-bit, codes above), opcode localparams (OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_LUI), funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
- Sub-module `alu_op_decode`: purely combinational decode (opcode/funct3/funct7 → op, alusrc, illegal); `alu_ctrl_stage` holds only the register, priority logic and counter.

## Test plan
- R-type sweep: opcode 0110011, f3 000/f7 0100000 → Operation 0110, ALUSrc 0 one cycle later; f3 101/f7 0100000 → 1111.
- I-type and memory: 0010011 f3 001 f7 0000001 → illegal_o=1, Operation 0000, counter 0→1; 0000011 → 0010, ALUSrc 1.
- Branch/JALR: 1100011 f3 101 → 1011; f3 010 → illegal; 1100111 f3 000 → 0011, ALUSrc 1.
- Stall then flush: capture SUB, assert stall 3 cycles with ADD at input → outputs hold 0110/valid 1; then flush+stall together → valid_o 0, Operation 0000.
- Counter saturation (CNT_WIDTH=2): 5 consecutive valid illegal captures → counts 1,2,3,3,3; an illegal instruction arriving with flush does not count.
- Reset mid-stream: reset while valid_o=1 and count=2 → next cycle all outputs 0, count 0; first capture after reset decodes normally.
